mesh_router_param: RTL

Parametrised five-port mesh router for the NoC, and the successor to the fixed-configuration edge and interior routers. One module covers all tile positions: a port-presence mask disables absent ports. Flit width and buffer depth are parameters. The router adds a flit-drop counter and per-port overflow flags. It uses per-input FIFOs, dimension-ordered (XY) routing, per-output round-robin arbitration, and credit-based flow control toward each neighbour.

---
 rtl/mesh_router_param_if.sv | 43 ++++
 rtl/mesh_router_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mesh_router_param_if.sv
// Flit, credit and status bundle between a mesh router and its five neighbours.
// Port index order in every 5-wide vector and flattened bus: 0=N, 1=S, 2=E, 3=W, 4=L.
//   in_data/in_valid   : flits arriving from neighbour p (slice p = [p*DATA_W +: DATA_W])
//   in_credit_o        : one-cycle credit return pulses toward neighbour p
//   out_data/out_valid : registered flits toward neighbour p
//   out_credit_i       : one-cycle credit pulses from neighbour p
//   drop_count         : saturating count of flits routed to absent ports
//   overflow           : sticky per-input overflow flags
// The slave modport is the router; the master modport is the surrounding fabric.
interface mesh_router_param_if #(
    parameter int unsigned DATA_W = 16
);
    logic [5*DATA_W-1:0] in_data;
    logic [4:0]          in_valid;
    logic [4:0]          in_credit_o;
    logic [5*DATA_W-1:0] out_data;
    logic [4:0]          out_valid;
    logic [4:0]          out_credit_i;
    logic [15:0]         drop_count;
    logic [4:0]          overflow;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_credit_o,
        output out_data,
        output out_valid,
        input  out_credit_i,
        output drop_count,
        output overflow
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_credit_o,
        input  out_data,
        input  out_valid,
        output out_credit_i,
        input  drop_count,
        input  overflow
    );
endinterface

// File: rtl/mesh_router_param.sv
// Parametrised five-port XY mesh router with per-input FIFOs, per-output
// round-robin arbitration and credit-based flow control.
// Ports:
//   clk  : router clock
//   rst  : asynchronous active-high reset
//   bus  : mesh_router_param_if.slave carrying flit, credit and status signals
// Parameters: XCOORD/YCOORD tile position, DATA_W flit width (dest X = [7:4],
// dest Y = [3:0]), FIFO_DEPTH input depth and initial credit, PORT_MASK presence.
module mesh_router_param #(
    parameter int unsigned XCOORD     = 0,
    parameter int unsigned YCOORD     = 0,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [4:0]  PORT_MASK  = 5'b11111
) (
    input  logic               clk,
    input  logic               rst,
    mesh_router_param_if.slave bus
);
    localparam int unsigned NP    = 5;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [3:0]       X_C      = 4'(XCOORD);
    localparam logic [3:0]       Y_C      = 4'(YCOORD);
    localparam logic [4:0]       CRED_MAX = 5'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_S = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    logic [DATA_W-1:0] r_mem    [NP][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr [NP];
    logic [PTR_W-1:0]  r_wr_ptr [NP];
    logic [CNT_W-1:0]  r_count  [NP];
    logic [4:0]        r_credit [NP];
    logic [NP-1:0]     r_prio   [NP];   // one-hot rotating priority per output
    logic [NP-1:0]     r_out_valid;
    logic [NP-1:0]     r_in_credit;
    logic [NP-1:0]     r_overflow;
    logic [NP*DATA_W-1:0] r_out_data;
    logic [15:0]       r_drop_count;

    logic [DATA_W-1:0] w_head      [NP];
    logic [2:0]        w_dir       [NP];
    logic [NP-1:0]     w_prio_next [NP];
    logic [NP-1:0]     w_has_flit;
    logic [NP-1:0]     w_drop;
    logic [NP-1:0]     w_pop;
    logic [NP-1:0]     w_wr;
    logic [NP-1:0]     w_ovf;
    logic [NP-1:0]     w_send;
    logic [NP*DATA_W-1:0] w_out_next;
    logic [2:0]        w_drop_n;
    logic [16:0]       w_drop_sum;

    // XY dimension-ordered route of a destination byte.
    function automatic logic [2:0] route(input logic [7:0] dest);
        logic [3:0] dx;
        logic [3:0] dy;
        dx = dest[7:4];
        dy = dest[3:0];
        if (dx > X_C)      route = P_E;
        else if (dx < X_C) route = P_W;
        else if (dy > Y_C) route = P_N;
        else if (dy < Y_C) route = P_S;
        else               route = P_L;
    endfunction

    // Head routing, absent-port drops, FIFO write/overflow and per-output arbitration.
    always_comb begin : route_arb
        int unsigned pidx;
        int unsigned idx;
        logic        found;
        pidx       = 0;
        idx        = 0;
        found      = 1'b0;
        w_drop     = '0;
        w_pop      = '0;
        w_send     = '0;
        w_wr       = '0;
        w_ovf      = '0;
        w_has_flit = '0;
        w_out_next = '0;
        w_drop_n   = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            w_head[p]      = r_mem[p][r_rd_ptr[p]];
            w_dir[p]       = route(w_head[p][7:0]);
            w_prio_next[p] = r_prio[p];
            w_has_flit[p]  = PORT_MASK[p] && (r_count[p] != '0);
            if (w_has_flit[p] && !PORT_MASK[w_dir[p]]) begin
                w_drop[p] = 1'b1;
                w_pop[p]  = 1'b1;
            end
            // Full is judged on the pre-pop count.
            w_wr[p]  = PORT_MASK[p] && bus.in_valid[p] && (r_count[p] != CNT_FULL);
            w_ovf[p] = PORT_MASK[p] && bus.in_valid[p] && (r_count[p] == CNT_FULL);
        end
        for (int unsigned o = 0; o < NP; o++) begin
            pidx = 0;
            for (int unsigned j = 0; j < NP; j++) begin
                if (r_prio[o][j]) pidx = j;
            end
            found = 1'b0;
            if (PORT_MASK[o] && (r_credit[o] != '0)) begin
                for (int unsigned k = 0; k < NP; k++) begin
                    idx = (pidx + k) % NP;
                    if (!found && w_has_flit[idx] && (w_dir[idx] == 3'(o))) begin
                        found          = 1'b1;
                        w_send[o]      = 1'b1;
                        w_pop[idx]     = 1'b1;
                        w_out_next[o*DATA_W +: DATA_W] = w_head[idx];
                        w_prio_next[o] = 5'(1) << ((idx + 1) % NP);
                    end
                end
            end
        end
        for (int unsigned p = 0; p < NP; p++) begin
            w_drop_n = w_drop_n + 3'(w_drop[p]);
        end
        w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_n);
    end

    // FIFO storage; contents need no reset because pointers and counts do.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NP; p++) begin
            if (w_wr[p]) r_mem[p][r_wr_ptr[p]] <= bus.in_data[p*DATA_W +: DATA_W];
        end
    end

    // Pointers, counts, credits, priorities and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned p = 0; p < NP; p++) begin
                r_rd_ptr[p] <= '0;
                r_wr_ptr[p] <= '0;
                r_count[p]  <= '0;
                r_credit[p] <= CRED_MAX;
                r_prio[p]   <= 5'b00001;
            end
            r_out_valid  <= '0;
            r_out_data   <= '0;
            r_in_credit  <= '0;
            r_overflow   <= '0;
            r_drop_count <= '0;
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                if (w_wr[p])  r_wr_ptr[p] <= r_wr_ptr[p] + PTR_W'(1);
                if (w_pop[p]) r_rd_ptr[p] <= r_rd_ptr[p] + PTR_W'(1);
                r_count[p] <= r_count[p] + CNT_W'(w_wr[p]) - CNT_W'(w_pop[p]);
                // A credit arriving with a send cancels it; extra credits at max are ignored.
                if (w_send[p] && !(PORT_MASK[p] && bus.out_credit_i[p])) begin
                    r_credit[p] <= r_credit[p] - 5'd1;
                end else if (!w_send[p] && PORT_MASK[p] && bus.out_credit_i[p]
                             && (r_credit[p] != CRED_MAX)) begin
                    r_credit[p] <= r_credit[p] + 5'd1;
                end
                r_prio[p] <= w_prio_next[p];
            end
            r_overflow   <= r_overflow | w_ovf;
            r_out_valid  <= w_send;
            r_out_data   <= w_out_next;
            r_in_credit  <= w_pop;
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.in_credit_o = r_in_credit;
    assign bus.overflow    = r_overflow;
    assign bus.drop_count  = r_drop_count;
endmodule
